// File: rtl/comp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM state encoding
// and the one-hot gt/eq/lt result record.
package comp_pkg;

    typedef enum logic [1:0] {
        CMP_IDLE = 2'd0,
        CMP_SCAN = 2'd1,
        CMP_DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    localparam cmp_res_t CMP_RES_NONE = '0;

    // Build a one-hot result from the digit comparator's greater/equal flags.
    function automatic cmp_res_t make_res(input logic g, input logic e);
        cmp_res_t r;
        r.gt = g;
        r.eq = e & ~g;
        r.lt = ~g & ~e;
        return r;
    endfunction

endpackage

// File: rtl/comp_digit.sv
// Combinational DIGIT-bit unsigned comparator. Walks the digit MSB-first with
// an equality chain: a bit position decides "greater" only if every bit above
// it matched. lt is implied by ~g & ~e and left to the caller.
module comp_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    output logic             g,
    output logic             e
);

    // eq_chain[i] is high when bits [DIGIT-1:i] of both operands match.
    logic [DIGIT:0]   eq_chain;
    logic [DIGIT-1:0] gt_bit;

    assign eq_chain[DIGIT] = 1'b1;

    // Per-bit stage: propagate equality down, flag the first A=1/B=0 bit.
    generate
        for (genvar gi = DIGIT - 1; gi >= 0; gi--) begin : g_bit
            assign eq_chain[gi] = eq_chain[gi+1] & ~(a_d[gi] ^ b_d[gi]);
            assign gt_bit[gi]   = eq_chain[gi+1] & a_d[gi] & ~b_d[gi];
        end
    endgenerate

    assign g = |gt_bit;
    assign e = eq_chain[0];

endmodule

// File: rtl/seq_mag_comp.sv
// Sequential WIDTH-bit magnitude comparator. Scans DIGIT bits per clock from
// the most significant digit down and stops at the first unequal digit.
// Valid/ready on both the operand and result sides; all outputs registered.
// Optional build macro: CMP_SIGNED_EN -- treat a/b as two's complement by
// flipping the sign bit of both operands in the top digit only.
module seq_mag_comp
    import comp_pkg::*;
#(
    parameter  int WIDTH = 10,
    parameter  int DIGIT = 2,
    localparam int NDIG  = WIDTH / DIGIT,
    localparam int CW    = $clog2(NDIG + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CW-1:0]    out_cycles
);

    // Digit index width; a single-digit build still needs a 1-bit index.
    localparam int             IW      = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0]  IDX_TOP = IW'(NDIG - 1);

    cmp_state_t       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IW-1:0]    idx_reg;
    logic [CW-1:0]    cnt_reg;
    cmp_res_t         res_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    // Latched operands split into digits; digit NDIG-1 is the most significant.
    logic [DIGIT-1:0] a_dig [NDIG];
    logic [DIGIT-1:0] b_dig [NDIG];

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
`ifdef CMP_SIGNED_EN
            if (gi == NDIG - 1) begin : g_sign
                // Flipping the sign bit on both sides maps two's complement
                // order onto unsigned order; lower digits need no change.
                localparam logic [DIGIT-1:0] SIGN_MASK = DIGIT'(1) << (DIGIT - 1);
                assign a_dig[gi] = a_reg[gi*DIGIT +: DIGIT] ^ SIGN_MASK;
                assign b_dig[gi] = b_reg[gi*DIGIT +: DIGIT] ^ SIGN_MASK;
            end else begin : g_plain
                assign a_dig[gi] = a_reg[gi*DIGIT +: DIGIT];
                assign b_dig[gi] = b_reg[gi*DIGIT +: DIGIT];
            end
`else
            assign a_dig[gi] = a_reg[gi*DIGIT +: DIGIT];
            assign b_dig[gi] = b_reg[gi*DIGIT +: DIGIT];
`endif
        end
    endgenerate

    logic [DIGIT-1:0] a_sel;
    logic [DIGIT-1:0] b_sel;
    logic             dig_g;
    logic             dig_e;

    assign a_sel = a_dig[idx_reg];
    assign b_sel = b_dig[idx_reg];

    // One shared digit comparator, steered by the scan index.
    comp_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d (a_sel),
        .b_d (b_sel),
        .g   (dig_g),
        .e   (dig_e)
    );

    // Control FSM: accept operands, scan digits MSB-first, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= CMP_IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            res_reg       <= CMP_RES_NONE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                CMP_IDLE: begin
                    if (in_valid) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        idx_reg      <= IDX_TOP;
                        cnt_reg      <= '0;
                        res_reg      <= CMP_RES_NONE;
                        in_ready_reg <= 1'b0;
                        state_reg    <= CMP_SCAN;
                    end
                end
                CMP_SCAN: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    if (!dig_e || idx_reg == '0) begin
                        // Either this digit decides, or all digits matched.
                        res_reg       <= make_res(dig_g, dig_e);
                        out_valid_reg <= 1'b1;
                        state_reg     <= CMP_DONE;
                    end else begin
                        idx_reg <= idx_reg - IW'(1);
                    end
                end
                CMP_DONE: begin
                    // Return to IDLE on the handshake; the next accept can
                    // happen no earlier than the following edge.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= CMP_IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= CMP_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign gt         = res_reg.gt;
    assign eq         = res_reg.eq;
    assign lt         = res_reg.lt;
    assign out_cycles = cnt_reg;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Directed bench for seq_mag_comp (WIDTH=10, DIGIT=2). Expected results are
// computed from the operands when they are issued, queued, and compared when
// the DUT raises out_valid.
module tb_seq_mag_comp;

    localparam int W  = 10;
    localparam int D  = 2;
    localparam int ND = W / D;
    localparam int CW = $clog2(ND + 1);

    typedef struct packed {
        logic          gt;
        logic          eq;
        logic          lt;
        logic [CW-1:0] cyc;
    } exp_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  a         = '0;
    logic [W-1:0]  b         = '0;
    logic          in_ready;
    logic          out_valid;
    logic          gt;
    logic          eq;
    logic          lt;
    logic [CW-1:0] out_cycles;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seq_mag_comp #(
        .WIDTH (W),
        .DIGIT (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .gt         (gt),
        .eq         (eq),
        .lt         (lt),
        .out_cycles (out_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: digits scanned = position of first unequal digit from the top.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t r;
        int   k   = 0;
        bit   hit = 1'b0;
        for (int d = ND - 1; d >= 0; d--) begin
            if (!hit) begin
                k++;
                if (av[d*D +: D] != bv[d*D +: D]) hit = 1'b1;
            end
        end
`ifdef CMP_SIGNED_EN
        r.gt = $signed(av) > $signed(bv);
        r.lt = $signed(av) < $signed(bv);
`else
        r.gt = av > bv;
        r.lt = av < bv;
`endif
        r.eq  = (av == bv);
        r.cyc = CW'(k);
        return r;
    endfunction

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        chk("in_ready_before_issue", in_ready, 1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        sb.push_back(model(av, bv));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    // Called #1 after the accept edge; counts edges until out_valid rises.
    task automatic wait_result(output exp_t e);
        int n = 0;
        chk("sb_depth", sb.size(), 1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        while (out_valid !== 1'b1 && n < ND + 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, e.cyc);
        chk("gt", gt, e.gt);
        chk("eq", eq, e.eq);
        chk("lt", lt, e.lt);
        chk("out_cycles", out_cycles, e.cyc);
        $display("[TB] txn: gt=%0b eq=%0b lt=%0b out_cycles=%0d latency=%0d (exp gt=%0b eq=%0b lt=%0b cyc=%0d)",
                 gt, eq, lt, out_cycles, n, e.gt, e.eq, e.lt, e.cyc);
        if (out_ready) begin
            @(posedge clk);
            #1;
            chk("post_hs_out_valid", out_valid, 0);
            chk("post_hs_in_ready", in_ready, 1);
        end
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res", {gt, eq, lt}, 0);
        chk("rst_out_cycles", out_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: early exit, gt
        issue(10'h3FF, 10'h000);
        wait_result(e);
        // 2: full scan, eq
        issue(10'h155, 10'h155);
        wait_result(e);
        // 3: LSB decides, lt
        issue(10'h001, 10'h002);
        wait_result(e);

        // 4: backpressure, with a second pair offered while busy
        out_ready = 1'b0;
        issue(10'h0F0, 10'h0E0);
        wait_result(e);
        in_valid = 1'b1;
        a        = '0;
        b        = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_res", {gt, eq, lt}, {e.gt, e.eq, e.lt});
            chk("bp_out_cycles", out_cycles, e.cyc);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        sb.push_back(model('0, '0));
        @(posedge clk);
        #1;
        chk("bp_hs_out_valid", out_valid, 0);
        chk("bp_hs_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_taken", in_ready, 0);
        wait_result(e);

        // 5: async reset mid-scan
        issue(10'h155, 10'h155);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_res", {gt, eq, lt}, 0);
        chk("midrst_out_cycles", out_cycles, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(10'h000, 10'h100);
        wait_result(e);

        // 6: sign-sensitive pair
        issue(10'h200, 10'h001);
        wait_result(e);

        // A few random pairs differing in one bit, to vary the exit digit
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            issue(ra, rb);
            wait_result(e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
